// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, WIDTH cycles.
// Optional signed-overflow output enabled by macro SERIAL_ADDER_OVF_EN.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   start in   begin an addition (sampled only in IDLE)
//   a, b  in   WIDTH-bit operands, captured on the accepted start edge
//   cin   in   carry-in, captured on the accepted start edge
//   busy  out  high while bits are being processed
//   done  out  one-cycle pulse when sum/cout are updated
//   sum   out  WIDTH-bit result, held until the next completion
//   cout  out  carry out of bit WIDTH-1, held like sum
//   ovf   out  signed overflow (only with SERIAL_ADDER_OVF_EN)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             bit_s;
  logic             bit_c;
  logic             last;

  // Single full-adder cell working on the current LSBs.
  always_comb begin
    bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c = (a_q[0] & b_q[0])
          | (a_q[0] & carry_q)
          | (b_q[0] & carry_q);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is in place.
    res_d = {bit_s, res_q[WIDTH-1:1]};
    last  = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_d;
          carry_q <= bit_c;
          if (last) begin
            sum_q   <= res_d;
            cout_q  <= bit_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry into the MSB is the carry entering this last bit
            ovf_q   <= carry_q ^ bit_c;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that performs a WIDTH-bit addition one bit per clock, using a single full-adder cell plus a carry flip-flop. It sits directly around the combinational full-adder stage: it shifts operand bits into the cell LSB-first, registers the carry out for the next bit, and collects the sum bits into a result register. It trades latency (WIDTH cycles) for area, and is the sequential consumer of the full adder's sum/cout outputs.

## Interface
- WIDTH, 8: operand and result width in bits; legal range WIDTH >= 2.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while an addition is in progress (SHIFT state).
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle onward.
- sum  output  WIDTH  result; held until the next accepted start completes.
- cout  output  1  carry-out of bit WIDTH-1; held like sum.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE: if start=1 at an edge -> load shift registers with a and b, load carry register with cin, clear bit counter, go SHIFT. Otherwise stay.
- SHIFT, each edge:
  - Bit sum = a_sr[0] ^ b_sr[0] ^ carry; bit carry = majority(a_sr[0], b_sr[0], carry).
  - a_sr, b_sr shift right by 1. The sum bit shifts into the MSB of the result shift register. The carry register takes the bit carry. The counter increments.
  - On the edge that processes bit WIDTH-1 (counter == WIDTH-1): copy the result into sum, copy the new carry into cout, go DONE.
- DONE: done=1 for exactly this cycle; the state returns to IDLE unconditionally on the next edge.
- start is ignored in SHIFT and DONE. It is not queued.
- sum/cout change only on the completion edge. There are no intermediate values on these ports.
- Arithmetic is unsigned modulo 2^WIDTH with carry in cout: {cout,sum} = a + b + cin.
- Counter width is $clog2(WIDTH). The counter never wraps within an operation.
- Operand inputs may change freely after the start edge without affecting the result.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; state IDLE; shift, carry and counter registers cleared.
- Reset asserted mid-operation: the operation is abandoned and all outputs return to reset values on that edge. No done pulse is produced.
- Start accepted at edge k:
  - busy=1 from edge k through edge k+WIDTH.
  - The result is registered at edge k+WIDTH. done=1 in the cycle following edge k+WIDTH, and busy=0 in that same cycle.
- Earliest next accepted start is at edge k+WIDTH+2, after the DONE -> IDLE transition at edge k+WIDTH+1. Throughput is one addition per WIDTH+2 cycles.
- Start held high continuously restarts automatically at each IDLE.

## Configuration
- SERIAL_ADDER_OVF_EN:
  - Defined: adds output ovf. ovf is the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1. It is registered on the completion edge alongside sum/cout and held until the next completion. Reset value is 0.
  - Undefined: no ovf port and no overflow logic; all other behaviour is identical.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, one-cycle start -> busy for 8 cycles, then done pulse; sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0 (carry register is not stale).
- Operation in progress with a=8'h12, b=8'h34; assert start with a=8'hFF, b=8'hFF at cycle 3 -> ignored; result sum=8'h46, cout=0, exactly one done pulse.
- Start a=8'hAA, b=8'h55; assert rst at cycle 4 -> on that edge busy=0, sum=0, cout=0; no done pulse; a subsequent start a=8'h01, b=8'h02 -> sum=8'h03.
- With SERIAL_ADDER_OVF_EN, a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1; a=8'hFF, b=8'h01 -> sum=8'h00, cout=1, ovf=0.
- Random sweep of 1000 operands with WIDTH=8 and WIDTH=13 -> {cout,sum} == a+b+cin every time; done always arrives WIDTH+1 cycles after start.
